// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU (alu_pipe).
//   - 3-bit opcode constants OP_ADD..OP_MUL
//   - FSM state encoding for the multiply sequencer
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_COMP = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle,
// LSB first. Returns the low WIDTH bits of the unsigned product.
// Present only when ALU_MUL_EN is defined.
// Ports:
//   clk     clock
//   rst     synchronous active-high reset; aborts a multiply in progress
//   start   latch a/b, clear accumulator, begin WIDTH iterations
//   a, b    operands (sampled on start)
//   busy    iterations in progress
//   done    high during the last iteration cycle; product valid alongside
//   product low WIDTH bits of a*b (valid when done)
`ifdef ALU_MUL_EN
module alu_mul_iter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] acc_step;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // The product is taken from the accumulator's next value so the caller can
  // register it on the same edge as the final iteration.
  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign product = acc_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_pipe.sv
// alu_pipe: EX-stage ALU with valid/ready handshake on both sides.
// Single-cycle ops: ADD, SUB, OR, XNOR, AND, COMP, SHL (latency 1).
// Opcode 7: iterative multiply (latency WIDTH+1) when ALU_MUL_EN is defined;
// otherwise a single-cycle op returning 0 with zero=1.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input beat handshake
//   a, b, shamt, sel      operands, shift amount, opcode
//   out_valid / out_ready output handshake
//   result                registered result
//   carry, borrow, zero   ADD carry-out, SUB borrow, result==0
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             borrow,
  output logic             zero
);

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             alu_accept;
  logic [WIDTH:0]   add_full;
  logic             a_lt_b;
  logic [WIDTH-1:0] shl_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_borrow;

  // ---------------- single-cycle datapath ----------------
  assign add_full = {1'b0, a} + {1'b0, b};
  assign a_lt_b   = (a < b);

  // Only non-power-of-2 widths can present shamt >= WIDTH.
  generate
    if ((2 ** SHW) != WIDTH) begin : g_shl_clip
      assign shl_res = (shamt >= SHW'(WIDTH)) ? '0 : (a << shamt);
    end else begin : g_shl_plain
      assign shl_res = a << shamt;
    end
  endgenerate

  always_comb begin
    alu_res    = '0;
    alu_carry  = 1'b0;
    alu_borrow = 1'b0;
    case (sel)
      OP_ADD: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
      end
      OP_SUB: begin
        alu_res    = a - b;
        alu_borrow = a_lt_b;
      end
      OP_OR:   alu_res = a | b;
      OP_XNOR: alu_res = ~(a ^ b);
      OP_AND:  alu_res = a & b;
      OP_COMP: alu_res = WIDTH'(a_lt_b);
      OP_SHL:  alu_res = shl_res;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  // ---------------- multiply sequencer ----------------
  alu_state_e       state_q, state_d;
  logic             start_mul;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  // busy mirrors the MUL state; both are required clear to take a beat.
  assign in_ready   = (state_q == S_IDLE) && !mul_busy && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign start_mul  = accept && (sel == OP_MUL);
  assign alu_accept = accept && !start_mul;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (start_mul),
    .a      (a),
    .b      (b),
    .busy   (mul_busy),
    .done   (mul_done),
    .product(mul_product)
  );
`else
  assign in_ready   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign alu_accept = accept;
`endif

  // ---------------- output register next-state ----------------
  always_comb begin
    result_d    = result_q;
    carry_d     = carry_q;
    borrow_d    = borrow_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
`ifdef ALU_MUL_EN
    state_d     = state_q;
`endif

    // Consume first; a same-cycle accept below re-asserts valid.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (alu_accept) begin
      result_d    = alu_res;
      carry_d     = alu_carry;
      borrow_d    = alu_borrow;
      zero_d      = (alu_res == '0);
      out_valid_d = 1'b1;
    end

`ifdef ALU_MUL_EN
    if (start_mul) state_d = S_MUL;

    if (mul_done) begin
      result_d    = mul_product;
      carry_d     = 1'b0;
      borrow_d    = 1'b0;
      zero_d      = (mul_product == '0);
      out_valid_d = 1'b1;
      state_d     = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q     <= S_IDLE;
`endif
    end else begin
      result_q    <= result_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_MUL_EN
      state_q     <= state_d;
`endif
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe at WIDTH=64.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [5:0]  shamt;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        carry;
  logic        borrow;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  alu_pipe #(
    .WIDTH(64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .sel      (sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .borrow   (borrow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; shamt = '0; sel = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 64'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", result); end
    n_cmp++; if ({carry, borrow, zero} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {carry, borrow, zero}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add;
    in_valid = 1'b1; sel = 3'd0; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %b want 1", out_valid); end
    n_cmp++; if (result !== 64'h0) begin n_err++; $display("FAIL add_result: got %h want 0", result); end
    n_cmp++; if ({carry, borrow, zero} !== 3'b101) begin n_err++; $display("FAIL add_flags cbz: got %b want 101", {carry, borrow, zero}); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 64'h0) begin n_err++; $display("FAIL add_drain_hold: got %h want 0", result); end
  endtask

  task automatic test_sub_comp;
    in_valid = 1'b1; sel = 3'd1; a = 64'h5; b = 64'h7; out_ready = 1'b1;
    tick;
    n_cmp++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL sub_result: got %h want fffffffffffffffe", result); end
    n_cmp++; if ({carry, borrow, zero} !== 3'b010) begin n_err++; $display("FAIL sub_flags cbz: got %b want 010", {carry, borrow, zero}); end
    sel = 3'd5;
    tick;
    n_cmp++; if (result !== 64'h1) begin n_err++; $display("FAIL comp_result: got %h want 1", result); end
    n_cmp++; if ({carry, borrow, zero} !== 3'b000) begin n_err++; $display("FAIL comp_flags cbz: got %b want 000", {carry, borrow, zero}); end
    sel = 3'd1; a = 64'h1234; b = 64'h1234;
    tick;
    n_cmp++; if ({result, carry, borrow, zero} !== {64'h0, 3'b001}) begin n_err++; $display("FAIL sub_equal: got %h cbz=%b want 0 cbz=001", result, {carry, borrow, zero}); end
    sel = 3'd5; a = 64'h9; b = 64'h3;
    tick;
    n_cmp++; if ({result, zero} !== {64'h0, 1'b1}) begin n_err++; $display("FAIL comp_ge: got %h z=%b want 0 z=1", result, zero); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [2:0]  sels [4];
    logic [63:0] exps [4];
    sels = '{3'd2, 3'd3, 3'd4, 3'd6};
    exps = '{64'hFC, 64'hFFFF_FFFF_FFFF_FF33, 64'h30, 64'hF00};
    a = 64'hF0; b = 64'h3C; shamt = 6'd4; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = sels[i];
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick;
      n_cmp++; if ({out_valid, result} !== {1'b1, exps[i]}) begin n_err++; $display("FAIL b2b_result[%0d]: got v=%b %h want v=1 %h", i, out_valid, result, exps[i]); end
    end
    sel = 3'd6; a = 64'h8000_0000_0000_0001; shamt = 6'd63;
    tick;
    n_cmp++; if ({result, zero} !== {64'h8000_0000_0000_0000, 1'b0}) begin n_err++; $display("FAIL shl_max: got %h z=%b want 8000000000000000 z=0", result, zero); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    in_valid = 1'b1; sel = 3'd0; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h31; out_ready = 1'b0;
    tick;
    // Offer a different beat while stalled; it must not be taken.
    sel = 3'd2; a = 64'h100; b = 64'h1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if ({out_valid, in_ready, result, carry, borrow, zero} !== {2'b10, 64'h30, 3'b100}) begin
        n_err++; $display("FAIL bp_stall[%0d]: got v=%b rdy=%b %h cbz=%b want v=1 rdy=0 30 cbz=100", i, out_valid, in_ready, result, {carry, borrow, zero});
      end
      tick;
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, result, carry} !== {1'b1, 64'h101, 1'b0}) begin n_err++; $display("FAIL bp_overwrite: got v=%b %h c=%b want v=1 101 c=0", out_valid, result, carry); end
    tick;
    n_cmp++; if ({out_valid, result} !== {1'b0, 64'h101}) begin n_err++; $display("FAIL bp_consume: got v=%b %h want v=0 101", out_valid, result); end
  endtask

`ifdef ALU_MUL_EN
  task automatic run_mul(input logic [63:0] ma, input logic [63:0] mb, input logic [63:0] exp, input logic exp_zero, input string tag);
    int unsigned cyc = 0;
    int unsigned low = 0;
    in_valid = 1'b1; sel = 3'd7; a = ma; b = mb; out_ready = 1'b1;
    tick;
    // A competing beat held during the multiply must be ignored.
    sel = 3'd0; a = 64'h1; b = 64'h1;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (in_ready === 1'b0) low++;
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (cyc != 64) begin n_err++; $display("FAIL %s_latency: got %0d cycles after accept cycle, want 64", tag, cyc); end
    n_cmp++; if (low != 64) begin n_err++; $display("FAIL %s_in_ready_low: got %0d cycles, want 64", tag, low); end
    n_cmp++; if (result !== exp) begin n_err++; $display("FAIL %s_result: got %h want %h", tag, result, exp); end
    n_cmp++; if ({carry, borrow, zero} !== {2'b00, exp_zero}) begin n_err++; $display("FAIL %s_flags cbz: got %b want 00%b", tag, {carry, borrow, zero}, exp_zero); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_done_in_ready: got %b want 1", tag, in_ready); end
    tick;
    n_cmp++; if ({out_valid, result} !== {1'b0, exp}) begin n_err++; $display("FAIL %s_drain: got v=%b %h want v=0 %h", tag, out_valid, result, exp); end
  endtask

  task automatic test_mul;
    run_mul(64'h1234, 64'h10, 64'h12340, 1'b0, "mul_basic");
    run_mul(64'h8000_0000_0000_0000, 64'h2, 64'h0, 1'b1, "mul_wrap0");
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, "mul_ones");
  endtask

  task automatic test_reset_mul;
    int unsigned seen = 0;
    // Leave a nonzero result behind so the reset clear is visible.
    in_valid = 1'b1; sel = 3'd2; a = 64'hA5; b = 64'h0; out_ready = 1'b1;
    tick;
    sel = 3'd7; a = 64'h1234; b = 64'h10;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 19; i++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    n_cmp++; if ({out_valid, result, in_ready} !== {1'b0, 64'h0, 1'b1}) begin n_err++; $display("FAIL rstmul_state: got v=%b %h rdy=%b want v=0 0 rdy=1", out_valid, result, in_ready); end
    for (int i = 0; i < 80; i++) begin
      if (out_valid !== 1'b0) seen++;
      tick;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL rstmul_ghost: out_valid high %0d cycles, want 0", seen); end
  endtask
`else
  task automatic test_reserved;
    in_valid = 1'b1; sel = 3'd2; a = 64'hA5; b = 64'h0; out_ready = 1'b1;
    tick;
    sel = 3'd7; a = 64'h5; b = 64'h3;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL op7_in_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, result, carry, borrow, zero} !== {1'b1, 64'h0, 3'b001}) begin n_err++; $display("FAIL op7_result: got v=%b %h cbz=%b want v=1 0 cbz=001", out_valid, result, {carry, borrow, zero}); end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_sub_comp;
    test_back_to_back;
    test_backpressure;
`ifdef ALU_MUL_EN
    test_mul;
    test_reset_mul;
`else
    test_reserved;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the 64-bit registered ALU.
- Width is configurable; a valid/ready handshake sits on both the input and output sides; carry, borrow and zero flags are produced.
- Adds an iterative multi-cycle multiply (shift-add) on the opcode that was previously unused.
- Sits in the EX stage of the 5-stage pipeline. It stalls upstream through in_ready while a multiply runs or the output is back-pressured.

Parameters:
- WIDTH, 64, operand and result width; must be ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand/op beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- shamt  input  SHW  shift amount.
- sel  input  3  opcode.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- carry  output  1  ADD carry-out; 0 for all other ops.
- borrow  output  1  SUB borrow (unsigned a<b); 0 for all other ops.
- zero  output  1  result==0.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Opcode map:
  - 0 ADD a+b.
  - 1 SUB a-b.
  - 2 OR.
  - 3 XNOR.
  - 4 AND.
  - 5 COMP: result = {WIDTH-1 zeros, (a<b unsigned)}.
  - 6 SHL: a << shamt, logical, zero fill.
  - 7 MUL: low WIDTH bits of a*b, unsigned.
- All arithmetic is modulo 2^WIDTH.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A full bubble-free pipeline is possible for single-cycle ops.
- FSM states: IDLE, MUL.
- IDLE, accept with sel≠7:
  - result and flags are registered and out_valid=1 on the next edge. Latency 1 cycle.
- IDLE, accept with sel=7:
  - Latch a, b; clear the accumulator; go to MUL.
  - Counter runs WIDTH cycles, one multiplier bit per cycle, LSB first.
- MUL, last iteration: load the product into result, set out_valid, return to IDLE.
  - Total latency WIDTH+1 cycles from accept to out_valid.
- While in MUL, in_ready=0; input pins are ignored.
- MUL never starts while out_valid && !out_ready, because in_ready=0 in that case. The product therefore always lands in an empty or draining output register.
- Back-pressure: while out_valid && !out_ready, result and flags hold stable and no new beat is accepted.
- Consume plus new accept in the same cycle: the output is overwritten with the new result; out_valid stays 1.
- Consume with no accept: out_valid falls to 0; result holds its last value.
- zero is computed on the final result for every op, including MUL.
- shamt ≥ WIDTH cannot occur, since SHW bits limit it when WIDTH is a power of 2. For non-power-of-2 WIDTH, shamt ≥ WIDTH gives 0.
- Reset:
  - state=IDLE, out_valid=0, result=0, carry=borrow=zero=0.
  - A multiply in progress is aborted and its result discarded.
  - in_ready=1 in the first cycle after reset deasserts.

Optional Feature:
- ALU_MUL_EN defined: opcode 7 is the iterative multiply described above.
- ALU_MUL_EN undefined:
  - No MUL state or multiplier logic is present.
  - Opcode 7 behaves as a single-cycle op returning 0 with zero=1, matching the previous generation's reserved slot.

Decomposition:
- Shared package alu_pkg:
  - localparam opcodes OP_ADD..OP_MUL (3-bit).
  - FSM state encoding.
- One sub-module alu_mul_iter:
  - Ports: clk, rst, start, a, b, busy, done, product.
  - Instantiated only under ALU_MUL_EN.
- Single-cycle ops stay inline in alu_pipe.

Test Plan:
1. WIDTH=64, sel=0, a=FFFF_FFFF_FFFF_FFFF, b=1, out_ready=1 -> next cycle result=0, carry=1, zero=1, out_valid=1.
2. sel=1, a=5, b=7 -> result=FFFF_FFFF_FFFF_FFFE, borrow=1. Then sel=5 with a=5, b=7 -> result=1.
3. Back-to-back beats sel=2,3,4,6 (a=F0, b=3C, shamt=4) with out_ready=1 -> one result per cycle: FC, FFFF_FFFF_FFFF_FF33, 30, F00; in_ready held 1 throughout.
4. out_ready=0 for 5 cycles after an ADD -> result/flags stable, in_ready=0. Then out_ready=1 -> in_ready=1 in the same cycle.
5. ALU_MUL_EN, sel=7, a=0x1234, b=0x10 -> in_ready=0 for 64 cycles; out_valid at accept+65; result=0x12340.
6. rst asserted at cycle 20 of a MUL -> next cycle out_valid=0, result=0, in_ready=1; the aborted product never appears.
